// File: rtl/defuzz_divider.sv
// Sequential defuzzifier: du = S_wg / S_w in Q1.15 via a one-bit-per-clock restoring divider.
// Optional build macro DEFUZZ_ROUND_EN adds a half bit and rounds half up instead of truncating.
`timescale 1ns/1ps

module defuzz_divider #(
    parameter int             W        = 16,
    parameter int             FRAC     = 15,
    parameter logic [W-1:0]   ZERO_OUT = 16'd0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] S_w,
    input  logic [W-1:0] S_wg,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] du,
    output logic         div_zero,
    output logic         sat,
    output logic         busy
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // once valid is raised, the producer holds it and its data stable until that edge.

`ifdef DEFUZZ_ROUND_EN
    localparam int ITERS = FRAC + 1;
`else
    localparam int ITERS = FRAC;
`endif
    localparam int           CNT_W = $clog2(ITERS + 1);
    localparam logic [W-1:0] MAXV  = {1'b0, {(W-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [W-1:0]     r_sw;
    logic [W:0]       r_rem;
    logic [W-1:0]     r_q;
    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_du;
    logic             r_div_zero;
    logic             r_sat;

    logic [W-1:0]     w_sw_c;
    logic [W-1:0]     w_swg_c;
    logic             w_accept;
    logic             w_zero;
    logic             w_over;
    logic             w_last;
    logic [W:0]       w_rem2;
    logic [W:0]       w_rem_sub;
    logic             w_bit;
    logic [W-1:0]     w_q_next;

    // Negative-looking operands are out of the nominal range; treat them as full scale.
    assign w_sw_c   = S_w[W-1]  ? MAXV : S_w;
    assign w_swg_c  = S_wg[W-1] ? MAXV : S_wg;
    assign w_accept = in_valid && (r_state == IDLE);
    assign w_zero   = (w_sw_c == '0);
    assign w_over   = (w_swg_c >= w_sw_c);
    assign w_last   = (r_cnt == CNT_W'(ITERS - 1));

    // rem < S_w < 2^(W-1), so the doubled remainder always fits in W+1 bits.
    assign w_rem2    = r_rem << 1;
    assign w_rem_sub = w_rem2 - {1'b0, r_sw};
    assign w_bit     = (w_rem2 >= {1'b0, r_sw});
    assign w_q_next  = (r_q << 1) | {{(W-1){1'b0}}, w_bit};

`ifdef DEFUZZ_ROUND_EN
    logic [W-1:0] w_sum;
    assign w_sum = {1'b0, w_q_next[W-1:1]} + {{(W-1){1'b0}}, w_q_next[0]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = (w_zero || w_over) ? DONE : CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw       <= '0;
            r_rem      <= '0;
            r_q        <= '0;
            r_cnt      <= '0;
            r_du       <= '0;
            r_div_zero <= 1'b0;
            r_sat      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_sw  <= w_sw_c;
                        r_rem <= {1'b0, w_swg_c};
                        r_q   <= '0;
                        r_cnt <= '0;
                        if (w_zero) begin
                            r_du       <= ZERO_OUT;
                            r_div_zero <= 1'b1;
                            r_sat      <= 1'b0;
                        end else if (w_over) begin
                            r_du       <= MAXV;
                            r_div_zero <= 1'b0;
                            r_sat      <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    r_rem <= w_bit ? w_rem_sub : w_rem2;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_div_zero <= 1'b0;
`ifdef DEFUZZ_ROUND_EN
                        // Rounding up from 32767.5 would overflow Q1.15; clamp instead.
                        r_du  <= w_sum[W-1] ? MAXV : w_sum;
                        r_sat <= w_sum[W-1];
`else
                        r_du  <= w_q_next & MAXV;
                        r_sat <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign du        = r_du;
    assign div_zero  = r_div_zero;
    assign sat       = r_sat;

endmodule
